// File: rtl/archinfo_pkg.sv
// Shared definitions for the archinfo init sequencer.
// Holds the register offsets of the archinfo slave, the sequencer step enum,
// the error code enum and the FSM state enum, plus small helpers that map a
// step to its register slot, byte offset and direction.
package archinfo_pkg;

    localparam logic [31:0] OFF_SYS = 32'h0000_0000;
    localparam logic [31:0] OFF_IDL = 32'h0000_0004;
    localparam logic [31:0] OFF_IDH = 32'h0000_0008;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Three writes followed by three read-backs, in register order.
    typedef enum logic [2:0] {
        STEP_W_SYS = 3'd0,
        STEP_W_IDL = 3'd1,
        STEP_W_IDH = 3'd2,
        STEP_R_SYS = 3'd3,
        STEP_R_IDL = 3'd4,
        STEP_R_IDH = 3'd5
    } step_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_SLVERR   = 2'd1,
        ERR_MISMATCH = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_e;

    // Register slot (0 SYS, 1 IDL, 2 IDH) addressed by a step: step % 3.
    function automatic logic [1:0] step_slot(input step_e s);
        logic [2:0] v;
        v = s;
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    function automatic logic [31:0] slot_offset(input logic [1:0] slot);
        case (slot)
            2'd0:    return OFF_SYS;
            2'd1:    return OFF_IDL;
            default: return OFF_IDH;
        endcase
    endfunction

    function automatic logic step_is_write(input step_e s);
        return (s <= STEP_W_IDH);
    endfunction

endpackage

// File: rtl/apb4_archinfo_init.sv
// APB4 master sequencer that programs the archinfo register block.
// After reset (AUTO_START) or on start_i it writes SYS, IDL and IDH with the
// configured values, reads each back and compares, then reports done/error.
//
// Ports
//   pclk, presetn       clock, asynchronous active-low reset
//   start_i             launch request, sampled only in IDLE or DONE
//   busy_o              sequence in progress (SETUP/ACCESS)
//   done_o              sequence finished, held until the next launch
//   err_o               with done_o: 1 = aborted or read-back mismatch
//   err_step_o          step of the first failure (0-2 writes, 3-5 reads)
//   err_code_o          0 none, 1 pslverr, 2 mismatch, 3 timeout
//   paddr_o..pstrb_o    APB4 master request signals
//   pready_i, prdata_i,
//   pslverr_i           APB4 slave response signals
//
// APB handshake: a transfer completes on the first cycle where
// psel_o & penable_o & pready_i are all high; prdata_i and pslverr_i are only
// looked at in that cycle. All request signals stay stable through ACCESS.
module apb4_archinfo_init
    import archinfo_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] SYS_VAL    = 32'h0000_0000,
    parameter logic [31:0] IDL_VAL    = 32'h0000_0000,
    parameter logic [31:0] IDH_VAL    = 32'h0000_0000,
    parameter bit          AUTO_START = 1'b1,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [2:0]  err_step_o,
    output logic [1:0]  err_code_o,
    output logic [31:0] paddr_o,
    output logic [2:0]  pprot_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    input  logic        pready_i,
    input  logic [31:0] prdata_i,
    input  logic        pslverr_i
);

    localparam int              CW      = $clog2(TIMEOUT + 1);
    // The cycle that would bring the wait counter to TIMEOUT is the last one.
    localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    step_e           step_q, step_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            first_q;
    logic            err_q, err_d;
    logic [2:0]      err_step_q, err_step_d;
    err_code_e       err_code_q, err_code_d;

    logic            in_xfer;
    logic            is_write;
    logic [1:0]      slot;
    logic [31:0]     cur_val;
    logic            abort;
    err_code_e       abort_code;

    assign in_xfer  = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign is_write = step_is_write(step_q);
    assign slot     = step_slot(step_q);

    always_comb begin
        cur_val = SYS_VAL;
        case (slot)
            2'd0:    cur_val = SYS_VAL;
            2'd1:    cur_val = IDL_VAL;
            default: cur_val = IDH_VAL;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= ST_IDLE;
            step_q     <= STEP_W_SYS;
            cnt_q      <= '0;
            first_q    <= 1'b1;
            err_q      <= 1'b0;
            err_step_q <= 3'd0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            first_q    <= 1'b0;
            err_q      <= err_d;
            err_step_q <= err_step_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        err_step_d = err_step_q;
        err_code_d = err_code_q;
        abort      = 1'b0;
        abort_code = ERR_NONE;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // first_q is only high on the first cycle after reset release,
                // so the automatic launch happens exactly once per reset.
                if (start_i || ((state_q == ST_IDLE) && AUTO_START && first_q)) begin
                    state_d    = ST_SETUP;
                    step_d     = STEP_W_SYS;
                    err_d      = 1'b0;
                    err_step_d = 3'd0;
                    err_code_d = ERR_NONE;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = '0;
            end
            ST_ACCESS: begin
                if (pready_i) begin
                    if (pslverr_i) begin
                        abort      = 1'b1;
                        abort_code = ERR_SLVERR;
                    end else if (!is_write && (prdata_i != cur_val)) begin
                        abort      = 1'b1;
                        abort_code = ERR_MISMATCH;
                    end else if (step_q == STEP_R_IDH) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d  = step_e'(step_q + 3'd1);
                        state_d = ST_SETUP;
                    end
                end else if (cnt_q == TO_LAST) begin
                    abort      = 1'b1;
                    abort_code = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d    = ST_DONE;
            err_d      = 1'b1;
            err_step_d = step_q;
            err_code_d = abort_code;
        end
    end

    // Bus outputs are decoded from registered state so reset clears them
    // asynchronously; everything is driven to zero outside a transfer.
    assign psel_o     = in_xfer;
    assign penable_o  = (state_q == ST_ACCESS);
    assign pwrite_o   = in_xfer && is_write;
    assign paddr_o    = in_xfer ? (BASE_ADDR + slot_offset(slot)) : 32'h0;
    assign pwdata_o   = (in_xfer && is_write) ? cur_val : 32'h0;
    assign pstrb_o    = (in_xfer && is_write) ? 4'hF : 4'h0;
    assign pprot_o    = 3'b000;

    assign busy_o     = in_xfer;
    assign done_o     = (state_q == ST_DONE);
    assign err_o      = err_q;
    assign err_step_o = err_step_q;
    assign err_code_o = err_code_q;

endmodule

// File: tb/tb_apb4_archinfo_init.sv
`timescale 1ns/1ps
// Bench for apb4_archinfo_init: an APB slave model with configurable wait
// states and fault injection, a reference model that predicts the transfer
// list and final status, and a monitor that pops predictions as the DUT
// completes transfers and sequences.
module tb_apb4_archinfo_init;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam logic [31:0] SYS  = 32'h0101_0001;
    localparam logic [31:0] IDL  = 32'h1234_5678;
    localparam logic [31:0] IDH  = 32'hCAFE_0002;
    localparam int          TMO  = 16;
    localparam int          DW   = 77;  // {write, addr, wdata, strb, access_cycles}
    localparam int          SW   = 14;  // {err, step, code, busy_cycles}

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, err_o;
    logic [2:0]  err_step_o;
    logic [1:0]  err_code_o;
    logic [31:0] paddr_o;
    logic [2:0]  pprot_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic        pready_i = 1'b0;
    logic [31:0] prdata_i = 32'h0;
    logic        pslverr_i = 1'b0;

    always #5 pclk = ~pclk;

    apb4_archinfo_init #(
        .BASE_ADDR (BASE),
        .SYS_VAL   (SYS),
        .IDL_VAL   (IDL),
        .IDH_VAL   (IDH),
        .AUTO_START(1'b1),
        .TIMEOUT   (TMO)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .start_i   (start_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .err_step_o(err_step_o),
        .err_code_o(err_code_o),
        .paddr_o   (paddr_o),
        .pprot_o   (pprot_o),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .pwrite_o  (pwrite_o),
        .pwdata_o  (pwdata_o),
        .pstrb_o   (pstrb_o),
        .pready_i  (pready_i),
        .prdata_i  (prdata_i),
        .pslverr_i (pslverr_i)
    );

    logic [DW-1:0] exp_q[$];
    logic [SW-1:0] exp_st_q[$];
    int total = 0;
    int bad   = 0;

    // Slave configuration: wait states per step (index 6 = unknown address),
    // fault kind (0 none, 1 pslverr, 2 bad read data, 3 never ready), fault step.
    int          ws_cfg[7];
    int          fault_kind;
    int          fault_step;
    logic [31:0] mem[3];

    // Monitor state
    int          wcnt;
    int          acc_cnt;
    int          busy_cnt;
    int          done_cnt = 0;
    logic        done_prev;
    logic        unstable;
    logic [68:0] cap;  // {write, addr, wdata, strb} seen on first ACCESS cycle

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cfg_val(input int slot);
        case (slot)
            0:       return SYS;
            1:       return IDL;
            default: return IDH;
        endcase
    endfunction

    function automatic int xfer_step(input logic [31:0] a, input logic w);
        logic [31:0] off;
        int          slot;
        off = a - BASE;
        if (off == 32'h0)      slot = 0;
        else if (off == 32'h4) slot = 1;
        else if (off == 32'h8) slot = 2;
        else return 6;
        return w ? slot : slot + 3;
    endfunction

    // Reference model: the sequence writes every register then reads each back,
    // stopping at the first failing step. Each transfer costs one SETUP cycle
    // plus its ACCESS cycles; busy spans exactly those cycles.
    task automatic push_expect();
        int          lat;
        int          slot;
        int          acc;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  st;
        lat = 0;
        for (int s = 0; s < 6; s++) begin
            slot = s % 3;
            wr   = (s < 3);
            acc  = (fault_kind == 3 && s == fault_step) ? TMO : ws_cfg[s] + 1;
            a    = BASE + 32'(4 * slot);
            d    = wr ? cfg_val(slot) : 32'h0;
            st   = wr ? 4'hF : 4'h0;
            exp_q.push_back({wr, a, d, st, 8'(acc)});
            lat += 1 + acc;
            if (fault_kind != 0 && s == fault_step) begin
                exp_st_q.push_back({1'b1, 3'(s), 2'(fault_kind), 8'(lat)});
                return;
            end
        end
        exp_st_q.push_back({1'b0, 3'd0, 2'd0, 8'(lat)});
    endtask

    task automatic set_cfg(input int k, input int fs, input int wsel, input int wval);
        for (int i = 0; i < 7; i++) ws_cfg[i] = 0;
        if (wsel >= 0) ws_cfg[wsel] = wval;
        fault_kind = k;
        fault_step = fs;
    endtask

    task automatic finish_xfer();
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL xfer_unexpected: got %0h expected none", cap);
        end else begin
            e = exp_q.pop_front();
            check("xfer", {cap, 8'(acc_cnt)}, e);
        end
        check("xfer_stable", unstable, 1'b0);
        check("pprot", pprot_o, 3'b000);
        acc_cnt  = 0;
        unstable = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 400) begin
            @(negedge pclk);
            #1;
            n++;
        end
        if (done_cnt < target) begin
            total++;
            bad++;
            $display("FAIL done_wait: got done_cnt=%0d expected %0d", done_cnt, target);
        end
    endtask

    task automatic pulse_start();
        @(negedge pclk);
        #1;
        start_i = 1'b1;
        @(negedge pclk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic run_one(input bit pulse_mid);
        int tgt;
        push_expect();
        tgt = done_cnt + 1;
        pulse_start();
        if (pulse_mid) begin
            repeat (2) @(negedge pclk);
            pulse_start();
        end
        wait_done(tgt);
        repeat (2) @(negedge pclk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus"}, {psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, pprot_o}, '0);
        check({tag, "_stat"}, {busy_o, done_o, err_o, err_step_o, err_code_o}, '0);
    endtask

    initial begin
        fork
            // Slave model and monitor, evaluated once per cycle on the falling edge.
            forever begin
                @(negedge pclk);
                if (!presetn) begin
                    pready_i  = 1'b0;
                    pslverr_i = 1'b0;
                    wcnt      = 0;
                    acc_cnt   = 0;
                    busy_cnt  = 0;
                    done_prev = 1'b0;
                    unstable  = 1'b0;
                end else begin
                    if (psel_o && penable_o) begin
                        int s;
                        int slot;
                        s    = xfer_step(paddr_o, pwrite_o);
                        slot = s % 3;
                        if (fault_kind == 3 && s == fault_step) begin
                            pready_i  = 1'b0;
                            pslverr_i = 1'($urandom_range(0, 1));
                            prdata_i  = $urandom;
                        end else if (wcnt < ws_cfg[s]) begin
                            wcnt++;
                            pready_i  = 1'b0;
                            pslverr_i = 1'($urandom_range(0, 1));
                            prdata_i  = $urandom;
                        end else begin
                            wcnt      = 0;
                            pready_i  = 1'b1;
                            pslverr_i = (fault_kind == 1 && s == fault_step);
                            if (pwrite_o) prdata_i = $urandom;
                            else if (fault_kind == 2 && s == fault_step) prdata_i = 32'hDEAD_BEEF;
                            else prdata_i = mem[slot];
                            if (pwrite_o && !pslverr_i && s < 6) mem[slot] = pwdata_o;
                        end
                    end else begin
                        wcnt      = 0;
                        pready_i  = 1'($urandom_range(0, 1));
                        pslverr_i = 1'($urandom_range(0, 1));
                        prdata_i  = $urandom;
                    end

                    if (busy_o) busy_cnt++;
                    if (psel_o && penable_o) begin
                        acc_cnt++;
                        if (acc_cnt == 1) cap = {pwrite_o, paddr_o, pwdata_o, pstrb_o};
                        else if (cap != {pwrite_o, paddr_o, pwdata_o, pstrb_o}) unstable = 1'b1;
                        if (pready_i) finish_xfer();
                    end else if (acc_cnt != 0) begin
                        // ACCESS ended without pready: the sequencer gave up.
                        finish_xfer();
                    end

                    if (done_o && !done_prev) begin
                        if (exp_st_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL status_unexpected: got err=%0d step=%0d code=%0d expected none",
                                     err_o, err_step_o, err_code_o);
                        end else begin
                            check("status", {err_o, err_step_o, err_code_o, 8'(busy_cnt)}, exp_st_q.pop_front());
                        end
                        busy_cnt = 0;
                        done_cnt++;
                    end
                    done_prev = done_o;
                end
            end

            // Stimulus
            begin
                int n;
                int tgt;
                for (int i = 0; i < 3; i++) mem[i] = 32'h0;
                set_cfg(0, 7, -1, 0);
                #1;
                check_all_zero("reset");

                // Automatic launch after reset release, zero-wait slave.
                push_expect();
                @(negedge pclk);
                #3;
                presetn = 1'b1;
                wait_done(1);
                check("done_held", {done_o, err_o}, 2'b10);
                repeat (3) @(negedge pclk);

                // Wait states on the IDL write, with an ignored start pulse mid-run.
                set_cfg(0, 7, 1, 3);
                run_one(1'b1);
                // Slave error on the IDH write: no reads follow.
                set_cfg(1, 2, -1, 0);
                run_one(1'b0);
                // Bad read-back data on SYS.
                set_cfg(2, 3, -1, 0);
                run_one(1'b0);
                // Slave never ready on the first write.
                set_cfg(3, 0, -1, 0);
                run_one(1'b0);

                // start_i held high: DONE relaunches on the following cycle.
                set_cfg(0, 7, 2, 1);
                push_expect();
                push_expect();
                tgt = done_cnt + 2;
                @(negedge pclk);
                #1;
                start_i = 1'b1;
                wait_done(tgt - 1);
                wait_done(tgt);
                start_i = 1'b0;
                repeat (2) @(negedge pclk);

                // Reset during the IDL read-back, then automatic relaunch.
                set_cfg(0, 7, -1, 0);
                push_expect();
                pulse_start();
                repeat (2) @(negedge pclk);
                pulse_start();
                n = 0;
                while (!(psel_o && penable_o && !pwrite_o && paddr_o == BASE + 32'h4) && n < 100) begin
                    @(negedge pclk);
                    #1;
                    n++;
                end
                check("reach_step4", {psel_o, penable_o, pwrite_o, paddr_o}, {1'b1, 1'b1, 1'b0, BASE + 32'h4});
                #2;
                presetn = 1'b0;
                #1;
                check_all_zero("midrst");
                exp_q.delete();
                exp_st_q.delete();
                repeat (3) @(negedge pclk);
                check_all_zero("midrst_hold");
                push_expect();
                tgt = done_cnt + 1;
                #3;
                presetn = 1'b1;
                wait_done(tgt);
                repeat (2) @(negedge pclk);

                // Randomised wait states and faults.
                for (int r = 0; r < 12; r++) begin
                    int k;
                    for (int i = 0; i < 6; i++) ws_cfg[i] = $urandom_range(0, 3);
                    ws_cfg[6] = 0;
                    k = $urandom_range(0, 3);
                    fault_kind = k;
                    if (k == 2) fault_step = $urandom_range(3, 5);
                    else if (k == 0) fault_step = 7;
                    else fault_step = $urandom_range(0, 5);
                    run_one(k == 0);
                end

                check("exp_q_empty", 32'(exp_q.size()), 32'd0);
                check("exp_st_q_empty", 32'(exp_st_q.size()), 32'd0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join
    end

endmodule
